// File: rtl/i2c_ball_frame_rx_if.sv
// Bus bundle between the I2C slave PHY / game logic and the ball frame decoder.
//   master : PHY + game side; drives bus_start, bus_stop, rx_valid, rx_byte,
//            ball_taken and observes the decoded ball state and status pulses.
//   slave  : frame decoder; consumes the byte stream and drives ball_y, ball_vy,
//            gravity_counter, is_collusion, is_win_flag, ball_pending,
//            frame_valid, frame_error, overrun and rx_busy.
interface i2c_ball_frame_rx_if;
    logic       bus_start;
    logic       bus_stop;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       ball_taken;
    logic [9:0] ball_y;
    logic [7:0] ball_vy;
    logic [1:0] gravity_counter;
    logic       is_collusion;
    logic       is_win_flag;
    logic       ball_pending;
    logic       frame_valid;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output bus_start, bus_stop, rx_valid, rx_byte, ball_taken,
        input  ball_y, ball_vy, gravity_counter, is_collusion, is_win_flag,
        input  ball_pending, frame_valid, frame_error, overrun, rx_busy
    );

    modport slave (
        input  bus_start, bus_stop, rx_valid, rx_byte, ball_taken,
        output ball_y, ball_vy, gravity_counter, is_collusion, is_win_flag,
        output ball_pending, frame_valid, frame_error, overrun, rx_busy
    );
endinterface

// File: rtl/i2c_ball_frame_rx.sv
// Receive-side ball frame decoder for the inter-board handoff link.
// Assembles FRAME_BYTES data bytes delivered by the I2C slave PHY between a
// START and a STOP, validates length and reserved bits, and commits the
// decoded ball state to registered outputs with a pending/taken handshake.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave modport of i2c_ball_frame_rx_if (PHY events, byte
//                stream, ball_taken in; decoded ball state and status out)
module i2c_ball_frame_rx #(
    parameter int FRAME_BYTES = 6,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_ball_frame_rx_if.slave    bus
);
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      timer;
    logic [7:0]       shadow   [FRAME_BYTES];
    logic [7:0]       shadow_n [FRAME_BYTES];
    logic [CNT_W-1:0] cnt_n;
    logic             store;
    logic             ovf;
    logic             expired;
    logic             good;

    // Reserved upper bits of the range-limited fields must be zero.
    function automatic logic fields_ok(input logic [7:0] b1, input logic [7:0] b3,
                                       input logic [7:0] b4, input logic [7:0] b5);
        return (b1[7:2] == 6'd0) && (b3[7:2] == 6'd0) &&
               (b4[7:1] == 7'd0) && (b5[7:1] == 7'd0);
    endfunction

    // The byte of this cycle is folded in before the stop is judged, so a
    // last byte arriving together with STOP still completes the frame.
    always_comb begin
        store   = bus.rx_valid && (cnt != CNT_FULL);
        ovf     = bus.rx_valid && (cnt == CNT_FULL);
        cnt_n   = store ? cnt + 1'b1 : cnt;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            shadow_n[i] = (store && (cnt == CNT_W'(i))) ? bus.rx_byte : shadow[i];
        end
        expired = (timer == 32'(TIMEOUT_CYC - 1));
        good    = !ovf && (cnt_n == CNT_FULL) &&
                  fields_ok(shadow_n[1], shadow_n[3], shadow_n[4], shadow_n[5]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            timer               <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) shadow[i] <= '0;
            bus.ball_y          <= '0;
            bus.ball_vy         <= '0;
            bus.gravity_counter <= '0;
            bus.is_collusion    <= 1'b0;
            bus.is_win_flag     <= 1'b0;
            bus.ball_pending    <= 1'b0;
            bus.frame_valid     <= 1'b0;
            bus.frame_error     <= 1'b0;
            bus.overrun         <= 1'b0;
            bus.rx_busy         <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            bus.overrun     <= 1'b0;
            // A commit later in this block overrides the clear, so a take
            // coinciding with a commit leaves the new ball pending.
            if (bus.ball_taken) bus.ball_pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.bus_start) begin
                        state       <= RECV;
                        bus.rx_busy <= 1'b1;
                        cnt         <= '0;
                        timer       <= '0;
                    end
                end
                RECV: begin
                    if (bus.bus_start) begin
                        // Repeated START: drop the partial frame and any byte of this cycle.
                        bus.frame_error <= 1'b1;
                        cnt             <= '0;
                        timer           <= '0;
                    end else if (bus.bus_stop) begin
                        state       <= IDLE;
                        bus.rx_busy <= 1'b0;
                        cnt         <= '0;
                        timer       <= '0;
                        shadow      <= shadow_n;
                        if (good) begin
                            bus.ball_y          <= {shadow_n[1][1:0], shadow_n[0]};
                            bus.ball_vy         <= shadow_n[2];
                            bus.gravity_counter <= shadow_n[3][1:0];
                            bus.is_collusion    <= shadow_n[4][0];
                            bus.is_win_flag     <= shadow_n[5][0];
                            bus.frame_valid     <= 1'b1;
                            bus.ball_pending    <= 1'b1;
                            bus.overrun         <= bus.ball_pending;
                        end else begin
                            bus.frame_error <= 1'b1;
                        end
                    end else if (ovf) begin
                        state <= DISCARD;
                        timer <= '0;
                    end else if (bus.rx_valid) begin
                        shadow <= shadow_n;
                        cnt    <= cnt_n;
                        timer  <= '0;
                    end else if (expired) begin
                        state           <= IDLE;
                        bus.rx_busy     <= 1'b0;
                        bus.frame_error <= 1'b1;
                        cnt             <= '0;
                        timer           <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DISCARD: begin
                    if (bus.bus_start) begin
                        state           <= RECV;
                        bus.frame_error <= 1'b1;
                        cnt             <= '0;
                        timer           <= '0;
                    end else if (bus.bus_stop || (!bus.rx_valid && expired)) begin
                        state           <= IDLE;
                        bus.rx_busy     <= 1'b0;
                        bus.frame_error <= 1'b1;
                        cnt             <= '0;
                        timer           <= '0;
                    end else if (bus.rx_valid) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.rx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_ball_frame_rx.sv
// Directed testbench for i2c_ball_frame_rx (TIMEOUT_CYC = 16).
module tb_i2c_ball_frame_rx;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    i2c_ball_frame_rx_if bus ();

    i2c_ball_frame_rx #(.FRAME_BYTES(6), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        bus.bus_start = 1'b1; step(); bus.bus_start = 1'b0;
    endtask

    task automatic send_stop();
        bus.bus_stop = 1'b1; step(); bus.bus_stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1; bus.rx_byte = b; step(); bus.rx_valid = 1'b0;
    endtask

    // f holds b0 in its top byte: 48'hb0_b1_b2_b3_b4_b5.
    task automatic send_bytes(input logic [47:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[47-8*i -: 8]);
    endtask

    task automatic send_frame(input logic [47:0] f);
        send_start();
        send_bytes(f, 6);
        send_stop();
    endtask

    task automatic check_ball(input string tag, input logic [9:0] y, input logic [7:0] vy,
                              input logic [1:0] g, input logic col, input logic win);
        check({tag, "_y"},   32'(bus.ball_y), 32'(y));
        check({tag, "_vy"},  32'(bus.ball_vy), 32'(vy));
        check({tag, "_g"},   32'(bus.gravity_counter), 32'(g));
        check({tag, "_col"}, 32'(bus.is_collusion), 32'(col));
        check({tag, "_win"}, 32'(bus.is_win_flag), 32'(win));
    endtask

    initial begin
        int k_err;
        bus.bus_start = 0; bus.bus_stop = 0; bus.rx_valid = 0;
        bus.rx_byte = 0; bus.ball_taken = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state
        check_ball("rst", 10'h0, 8'h0, 2'd0, 1'b0, 1'b0);
        check("rst_pend", 32'(bus.ball_pending), 0);
        check("rst_busy", 32'(bus.rx_busy), 0);
        check("rst_fv", 32'(bus.frame_valid), 0);
        check("rst_fe", 32'(bus.frame_error), 0);

        // Reset mid-frame after 4 bytes
        send_start();
        send_bytes(48'h2C01FD020100, 4);
        check("mid_busy_pre", 32'(bus.rx_busy), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_busy", 32'(bus.rx_busy), 0);
        check("mid_fe", 32'(bus.frame_error), 0);
        check("mid_pend", 32'(bus.ball_pending), 0);
        check_ball("mid", 10'h0, 8'h0, 2'd0, 1'b0, 1'b0);
        step();
        check("mid_fe2", 32'(bus.frame_error), 0);

        // Good frame
        send_frame(48'h2C01FD020100);
        check("good_fv", 32'(bus.frame_valid), 1);
        check("good_fe", 32'(bus.frame_error), 0);
        check("good_pend", 32'(bus.ball_pending), 1);
        check("good_ovr", 32'(bus.overrun), 0);
        check("good_busy", 32'(bus.rx_busy), 0);
        check_ball("good", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);
        step();
        check("good_fv_pulse", 32'(bus.frame_valid), 0);

        // Short frame: stop after 5 bytes
        send_start();
        send_bytes(48'h110022010000, 5);
        send_stop();
        check("short_fe", 32'(bus.frame_error), 1);
        check("short_fv", 32'(bus.frame_valid), 0);
        check("short_pend", 32'(bus.ball_pending), 1);
        check_ball("short", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);
        step();
        check("short_fe_pulse", 32'(bus.frame_error), 0);

        // Field error: b3 = 0x05
        send_frame(48'h330144050000);
        check("field_fe", 32'(bus.frame_error), 1);
        check("field_fv", 32'(bus.frame_valid), 0);
        check_ball("field", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);

        // Overflow: 7 bytes then stop
        send_start();
        send_bytes(48'h010000000000, 6);
        send_byte(8'h00);
        check("ovf_busy", 32'(bus.rx_busy), 1);
        check("ovf_fe_early", 32'(bus.frame_error), 0);
        send_stop();
        check("ovf_fe", 32'(bus.frame_error), 1);
        check("ovf_fv", 32'(bus.frame_valid), 0);
        check("ovf_busy_after", 32'(bus.rx_busy), 0);
        step();
        check("ovf_fe_once", 32'(bus.frame_error), 0);
        check_ball("ovf", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);

        // Second good frame while still pending -> overrun
        send_frame(48'h050210010001);
        check("ovr_fv", 32'(bus.frame_valid), 1);
        check("ovr_ovr", 32'(bus.overrun), 1);
        check("ovr_pend", 32'(bus.ball_pending), 1);
        check_ball("ovr", 10'h205, 8'h10, 2'd1, 1'b0, 1'b1);
        step();
        check("ovr_pulse", 32'(bus.overrun), 0);

        // Take, then take while not pending
        bus.ball_taken = 1'b1; step();
        check("take_pend", 32'(bus.ball_pending), 0);
        step(); bus.ball_taken = 1'b0;
        check("take_idle_pend", 32'(bus.ball_pending), 0);

        // Last byte together with stop, commit with no overrun
        send_start();
        send_bytes(48'h000380030000, 5);
        bus.rx_valid = 1'b1; bus.rx_byte = 8'h00; bus.bus_stop = 1'b1;
        step();
        bus.rx_valid = 1'b0; bus.bus_stop = 1'b0;
        check("same_fv", 32'(bus.frame_valid), 1);
        check("same_ovr", 32'(bus.overrun), 0);
        check_ball("same", 10'h300, 8'h80, 2'd3, 1'b0, 1'b0);

        // Commit coinciding with ball_taken -> stays pending
        send_start();
        send_bytes(48'h2C01FD020100, 6);
        bus.bus_stop = 1'b1; bus.ball_taken = 1'b1;
        step();
        bus.bus_stop = 1'b0; bus.ball_taken = 1'b0;
        check("tc_fv", 32'(bus.frame_valid), 1);
        check("tc_pend", 32'(bus.ball_pending), 1);
        check("tc_ovr", 32'(bus.overrun), 1);
        bus.ball_taken = 1'b1; step(); bus.ball_taken = 1'b0;
        check("tc_pend_clr", 32'(bus.ball_pending), 0);

        // Timeout: 3 bytes then silence
        send_start();
        send_bytes(48'h010000000000, 3);
        k_err = -1;
        for (int k = 1; k <= 40 && k_err < 0; k++) begin
            step();
            if (bus.frame_error) k_err = k;
        end
        check("tmo_cycles", 32'(k_err), 16);
        check("tmo_busy", 32'(bus.rx_busy), 0);
        check_ball("tmo", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);

        // Repeated START after 2 bytes, then a full good frame
        send_start();
        send_bytes(48'h990000000000, 2);
        send_start();
        check("rs_fe", 32'(bus.frame_error), 1);
        check("rs_busy", 32'(bus.rx_busy), 1);
        send_bytes(48'h050210010001, 6);
        check("rs_fe_once", 32'(bus.frame_error), 0);
        send_stop();
        check("rs_fv", 32'(bus.frame_valid), 1);
        check("rs_fe_commit", 32'(bus.frame_error), 0);
        check_ball("rs", 10'h205, 8'h10, 2'd1, 1'b0, 1'b1);

        // Back-to-back: start in the cycle right after stop
        send_frame(48'h2C01FD020100);
        check("b2b_fv", 32'(bus.frame_valid), 1);
        check_ball("b2b", 10'h12C, 8'hFD, 2'd2, 1'b1, 1'b0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
